// File: rtl/fb_arbiter_if.sv
// Bus bundle between fb_arbiter and its neighbours: LCD pixel pop side,
// renderer write port and framebuffer SRAM port.
interface fb_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH = 24
);
  logic                  i_FrameStart;
  logic                  i_PopPx;
  logic [DATA_WIDTH-1:0] o_Px;
  logic                  o_PxValid;
  logic                  o_Underflow;
  logic                  i_WrValid;
  logic [ADDR_WIDTH-1:0] i_WrAddr;
  logic [DATA_WIDTH-1:0] i_WrData;
  logic                  o_WrReady;
  logic [ADDR_WIDTH-1:0] o_MemAddr;
  logic                  o_MemWe;
  logic [DATA_WIDTH-1:0] o_MemWData;
  logic [DATA_WIDTH-1:0] i_MemRData;

  modport slave (
    input  i_FrameStart, i_PopPx, i_WrValid, i_WrAddr, i_WrData, i_MemRData,
    output o_Px, o_PxValid, o_Underflow, o_WrReady, o_MemAddr, o_MemWe, o_MemWData
  );

  modport master (
    output i_FrameStart, i_PopPx, i_WrValid, i_WrAddr, i_WrData, i_MemRData,
    input  o_Px, o_PxValid, o_Underflow, o_WrReady, o_MemAddr, o_MemWe, o_MemWData
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: raster-order display prefetch into a small
// FIFO with deadline priority, leftover memory cycles go to renderer writes.
module fb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned H_PX       = 800,
  parameter int unsigned V_PX       = 480,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LOW_WATER  = 8
) (
  input  logic         i_CLK,
  input  logic         i_RSTn,
  fb_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RES_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_PX * V_PX - 1);

  localparam logic [0:0] WAIT_FRAME = 1'b0;
  localparam logic [0:0] RUN        = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  gen_q, gen_d;
  logic                  rd1_vld_q, rd1_vld_d, rd1_gen_q, rd1_gen_d;
  logic                  rd2_vld_q, rd2_vld_d, rd2_gen_q, rd2_gen_d;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  underflow_q, underflow_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic             run, urgent, rd_grant, wr_grant, wr_ready;
  logic             live1, live2, push, pop_ok, fs;
  logic [RES_W-1:0] reserve;

  always_comb begin
    fs       = bus.i_FrameStart;
    run      = (state_q == RUN);
    // Reads from an older generation are already squashed and no longer reserve space.
    live1    = rd1_vld_q && (rd1_gen_q == gen_q);
    live2    = rd2_vld_q && (rd2_gen_q == gen_q);
    reserve  = RES_W'(count_q) + RES_W'(live1) + RES_W'(live2);
    urgent   = run && (reserve < RES_W'(LOW_WATER));
    wr_ready = !urgent;
    rd_grant = run && !fs &&
               (urgent || (!bus.i_WrValid && (reserve < RES_W'(FIFO_DEPTH))));
    wr_grant = !rd_grant && bus.i_WrValid && wr_ready;
    pop_ok   = bus.i_PopPx && (count_q != '0);
    push     = live2 && !fs;
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    gen_d       = gen_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop_ok);
    underflow_d = underflow_q || (bus.i_PopPx && (count_q == '0));
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rd1_vld_d   = rd_grant;
    rd1_gen_d   = gen_q;
    rd2_vld_d   = rd1_vld_q;
    rd2_gen_d   = rd1_gen_q;

    if (push) begin
      fifo_d[wr_ptr_q] = bus.i_MemRData;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (rd_grant) begin
      mem_addr_d = rd_addr_q;
      if (rd_addr_q == LAST_ADDR) begin
        state_d = WAIT_FRAME;
      end else begin
        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
      end
    end else if (wr_grant) begin
      mem_addr_d  = bus.i_WrAddr;
      mem_we_d    = 1'b1;
      mem_wdata_d = bus.i_WrData;
    end

    // Flipping the generation orphans both pipeline stages without touching them.
    if (fs) begin
      state_d   = RUN;
      rd_addr_d = '0;
      gen_d     = !gen_q;
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q     <= WAIT_FRAME;
      rd_addr_q   <= '0;
      gen_q       <= 1'b0;
      rd1_vld_q   <= 1'b0;
      rd1_gen_q   <= 1'b0;
      rd2_vld_q   <= 1'b0;
      rd2_gen_q   <= 1'b0;
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      gen_q       <= gen_d;
      rd1_vld_q   <= rd1_vld_d;
      rd1_gen_q   <= rd1_gen_d;
      rd2_vld_q   <= rd2_vld_d;
      rd2_gen_q   <= rd2_gen_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.o_Px        = fifo_q[rd_ptr_q];
  assign bus.o_PxValid   = (count_q != '0);
  assign bus.o_Underflow = underflow_q;
  assign bus.o_WrReady   = wr_ready;
  assign bus.o_MemAddr   = mem_addr_q;
  assign bus.o_MemWe     = mem_we_q;
  assign bus.o_MemWData  = mem_wdata_q;

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port framebuffer arbiter between the LCD display path and the Julia renderer. It prefetches pixels from framebuffer memory in raster order into a small FIFO that the LCD timing side pops one pixel per data-enable cycle. It grants leftover memory cycles to renderer writes. Display reads carry a hard deadline and win whenever FIFO reserve is low. The block sits between the framebuffer SRAM, the renderer write port and the LCD timing generator's RGB input.

## Interface
- ADDR_WIDTH, 19, framebuffer word address width
- DATA_WIDTH, 24, pixel width (RGB888)
- H_PX, 800, active pixels per line
- V_PX, 480, active lines per frame
- FIFO_DEPTH, 16, prefetch FIFO entries (power of two)
- LOW_WATER, 8, reserve threshold below which reads are urgent
- i_CLK  in  1  clock; all state on rising edge
- i_RSTn  in  1  asynchronous active-low reset
- i_FrameStart  in  1  one-cycle pulse: restart display read at address 0
- i_PopPx  in  1  consumer takes o_Px this cycle
- o_Px  out  DATA_WIDTH  FIFO head pixel
- o_PxValid  out  1  FIFO non-empty
- o_Underflow  out  1  sticky: pop seen while empty
- i_WrValid  in  1  renderer write request
- i_WrAddr  in  ADDR_WIDTH  renderer write address
- i_WrData  in  DATA_WIDTH  renderer write data
- o_WrReady  out  1  write accepted when i_WrValid & o_WrReady
- o_MemAddr  out  ADDR_WIDTH  registered memory address
- o_MemWe  out  1  registered write enable
- o_MemWData  out  DATA_WIDTH  registered write data
- i_MemRData  in  DATA_WIDTH  read data, valid one cycle after o_MemAddr read cycle

## Operation
- States: WAIT_FRAME (no display reads) and RUN (display reads pending). Reset enters WAIT_FRAME. i_FrameStart in any state goes to RUN, sets read pointer RdAddr=0, flushes the FIFO and squashes in-flight reads. When RdAddr has issued H_PX*V_PX-1, go to WAIT_FRAME.
- Reserve = FIFO occupancy + in-flight reads (0..2).
- Per-cycle grant, at most one:
  - Urgent read: RUN and Reserve < LOW_WATER.
  - Else write: i_WrValid.
  - Else opportunistic read: RUN and Reserve < FIFO_DEPTH.
  - Else idle.
- o_WrReady = !(RUN && Reserve < LOW_WATER). It is independent of i_WrValid. It is 1 in WAIT_FRAME.
- Grant at cycle t drives o_MemAddr/o_MemWe/o_MemWData during t+1. Read data arrives on i_MemRData at t+2 and is pushed into the FIFO at the end of t+2. o_PxValid can rise at t+3.
- An idle cycle keeps o_MemAddr unchanged with o_MemWe=0.
- Pop and push in the same cycle are both performed. Occupancy never exceeds FIFO_DEPTH by construction.
- i_PopPx while empty: ignored, and o_Underflow is set. Only reset clears o_Underflow.
- Squash: a read granted before i_FrameStart must not enter the FIFO. Tag in-flight reads with a generation bit.
- Arithmetic: RdAddr is ADDR_WIDTH unsigned and never wraps. H_PX*V_PX must be ≤ 2^ADDR_WIDTH.

## Timing
- Reset values:
  - o_MemAddr=0, o_MemWe=0, o_MemWData=0
  - o_Px=0, o_PxValid=0, o_Underflow=0
  - o_WrReady=1 (WAIT_FRAME), RdAddr=0, FIFO empty, in-flight=0
- Async assertion mid-operation clears everything immediately. Deassertion is synchronous to i_CLK via an external synchronizer.
- Read latency from i_FrameStart cycle to first o_PxValid: 4 cycles. Grant is in the cycle after the pulse.
- Throughput: one memory op per cycle. Sustained pop at 1/clk is met only when writes use ≤0 cycles during active pixels. The renderer is throttled by o_WrReady.

## Test plan
- Reset, then hold idle 10 cycles -> all outputs at reset values, o_WrReady=1, no memory activity.
- Pulse i_FrameStart, no pops, no writes -> o_MemAddr reads 0..15 on consecutive cycles, then o_MemWe=0 idle. o_PxValid rises 4 cycles after the pulse. FIFO holds the data for addresses 0..15.
- Pulse i_FrameStart, pop every cycle, i_WrValid held high with incrementing addr/data -> no o_Underflow. Writes appear on o_Mem* one cycle after acceptance. o_WrReady=0 exactly when Reserve<8.
- Run a full frame with H_PX=4, V_PX=2 -> exactly 8 reads at addresses 0..7, then WAIT_FRAME. Later writes get o_WrReady=1 every cycle.
- Issue i_FrameStart while 2 reads are in flight and the FIFO holds 5 -> o_PxValid=0 next cycle, squashed data is never popped, and the next read address is 0.
- Pop while empty -> o_Underflow=1 and stays 1. Assert i_RSTn=0 mid-frame -> o_Underflow=0, state WAIT_FRAME, o_PxValid=0 immediately.
